// File: rtl/alu_pkg.sv
// alu_pkg: shared encodings for the EX-stage flag resolver.
//   br_cond_e : branch-condition field carried with each ALU result
//   state_e   : resolver control state (normal flow vs. waiting for flush
//               after an overflow trap)
//   PC_INC    : instruction size added to the PC for branch targets
//   br_taken  : taken decision from the condition field and the Z flag
package alu_pkg;

  typedef enum logic [1:0] {
    BR_NONE   = 2'b00,
    BR_NZ     = 2'b01,
    BR_Z      = 2'b10,
    BR_ALWAYS = 2'b11
  } br_cond_e;

  typedef enum logic {
    ST_RUN       = 1'b0,
    ST_TRAP_WAIT = 1'b1
  } state_e;

  localparam int unsigned PC_INC = 4;

  function automatic logic br_taken(input logic [1:0] cond, input logic z);
    logic taken;
    taken = 1'b0;
    unique case (br_cond_e'(cond))
      BR_NONE:   taken = 1'b0;
      BR_NZ:     taken = !z;
      BR_Z:      taken = z;
      BR_ALWAYS: taken = 1'b1;
      default:   taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/alu_flag_resolve_if.sv
// alu_flag_resolve_if: bundle of the resolver's data-path signals.
//   in_*           : ALU result, flags and branch info from EX (valid/ready)
//   out_*          : buffered result towards MEM (valid/ready)
//   redirect_*     : fetch redirect for taken branches
//   ovf_trap/trap_pc : precise signed-overflow trap report
// Modports:
//   slave  : the resolver itself
//   master : the environment (EX producer, MEM consumer, fetch, trap unit)
interface alu_flag_resolve_if #(
  parameter int WIDTH  = 32,
  parameter int REG_AW = 5
);

  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  in_S;
  logic              in_Z;
  logic              in_V;
  logic              in_N;
  logic              in_sign;
  logic [1:0]        in_br_cond;
  logic [WIDTH-1:0]  in_pc;
  logic [WIDTH-1:0]  in_br_off;
  logic [REG_AW-1:0] in_rd;
  logic              in_wr_en;

  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  out_S;
  logic              out_N;
  logic [REG_AW-1:0] out_rd;
  logic              out_wr_en;

  logic              redirect_valid;
  logic [WIDTH-1:0]  redirect_pc;
  logic              ovf_trap;
  logic [WIDTH-1:0]  trap_pc;

  modport slave (
    input  in_valid, in_S, in_Z, in_V, in_N, in_sign, in_br_cond,
           in_pc, in_br_off, in_rd, in_wr_en, out_ready,
    output in_ready, out_valid, out_S, out_N, out_rd, out_wr_en,
           redirect_valid, redirect_pc, ovf_trap, trap_pc
  );

  modport master (
    output in_valid, in_S, in_Z, in_V, in_N, in_sign, in_br_cond,
           in_pc, in_br_off, in_rd, in_wr_en, out_ready,
    input  in_ready, out_valid, out_S, out_N, out_rd, out_wr_en,
           redirect_valid, redirect_pc, ovf_trap, trap_pc
  );

endinterface

// File: rtl/alu_skid_buf.sv
// alu_skid_buf: generic 2-entry valid/ready skid buffer.
//   clk, rst_n  : clock, synchronous active-low reset
//   clr         : drop both entries at the next edge
//   push_valid  : push this cycle (caller has already qualified with push_ready)
//   push_ready  : registered; 1 while the skid entry is empty
//   push_data   : payload to enqueue
//   pop_valid   : main entry holds data (oldest entry)
//   pop_ready   : consumer takes the main entry this cycle
//   pop_data    : main entry payload, stable while pop_valid && !pop_ready
module alu_skid_buf #(
  parameter int PAYLOAD_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 push_valid,
  output logic                 push_ready,
  input  logic [PAYLOAD_W-1:0] push_data,
  output logic                 pop_valid,
  input  logic                 pop_ready,
  output logic [PAYLOAD_W-1:0] pop_data
);

  logic                 main_v, skid_v;
  logic [PAYLOAD_W-1:0] main_d, skid_d;
  logic                 pop;

  assign pop        = main_v && pop_ready;
  assign push_ready = !skid_v;
  assign pop_valid  = main_v;
  assign pop_data   = main_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
      main_d <= '0;
      skid_d <= '0;
    end else if (clr) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
    end else if (pop) begin
      // Skid entry (if any) moves forward; a simultaneous push refills
      // whichever slot is now free, so a pop+push never bubbles.
      if (skid_v) begin
        main_d <= skid_d;
        skid_v <= push_valid;
        if (push_valid) skid_d <= push_data;
      end else begin
        main_v <= push_valid;
        if (push_valid) main_d <= push_data;
      end
    end else if (push_valid) begin
      if (!main_v) begin
        main_v <= 1'b1;
        main_d <= push_data;
      end else begin
        skid_v <= 1'b1;
        skid_d <= push_data;
      end
    end
  end

endmodule

// File: rtl/alu_flag_resolve.sv
// alu_flag_resolve: EX-stage consumer of the ALU S/Z/V/N outputs.
// Buffers each accepted result in a 2-entry skid buffer towards MEM,
// resolves conditional branches from Z (fetch redirect pulse) and raises a
// precise overflow trap from V on signed ops.
//   clk    : clock
//   rst_n  : synchronous active-low reset
//   flush  : pipeline flush; clears buffer, blocks accept, cancels pulses,
//            releases the post-trap wait
//   bus    : alu_flag_resolve_if.slave (in_* handshake, out_* handshake,
//            redirect_valid/redirect_pc, ovf_trap/trap_pc)
module alu_flag_resolve
  import alu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int REG_AW = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  alu_flag_resolve_if.slave    bus
);

  localparam int PAYLOAD_W = WIDTH + REG_AW + 2;

  state_e                 state_q, state_d;
  logic                   buf_ready;
  logic                   buf_vld;
  logic                   accept_p0;
  logic                   trap_p0;
  logic                   taken_p0;
  logic [PAYLOAD_W-1:0]   push_data_p0;
  logic [PAYLOAD_W-1:0]   pop_data;
  logic                   redir_vld_p1, trap_vld_p1;
  logic [WIDTH-1:0]       redir_pc_p1, trap_pc_p1;

  // ---- p0: accept, flag evaluation ----
  // Ready is built from registered state only, except flush, which must
  // block the accept in its own cycle.
  assign bus.in_ready = buf_ready && (state_q == ST_RUN) && !flush;
  assign accept_p0    = bus.in_valid && bus.in_ready;
  // V only means overflow for signed ops; a trap overrides any branch.
  assign trap_p0      = bus.in_sign && bus.in_V;
  assign taken_p0     = br_taken(bus.in_br_cond, bus.in_Z) && !trap_p0;
  // Trapped entries still flow to MEM but must not write the register file.
  assign push_data_p0 = {bus.in_S, bus.in_N, bus.in_rd, bus.in_wr_en && !trap_p0};

  alu_skid_buf #(
    .PAYLOAD_W (PAYLOAD_W)
  ) u_skid (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (flush),
    .push_valid (accept_p0),
    .push_ready (buf_ready),
    .push_data  (push_data_p0),
    .pop_valid  (buf_vld),
    .pop_ready  (bus.out_ready),
    .pop_data   (pop_data)
  );

  assign bus.out_valid = buf_vld;
  assign {bus.out_S, bus.out_N, bus.out_rd, bus.out_wr_en} = pop_data;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_RUN;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RUN:       if (accept_p0 && trap_p0) state_d = ST_TRAP_WAIT;
      ST_TRAP_WAIT: if (flush)                state_d = ST_RUN;
      default:                                state_d = ST_RUN;
    endcase
  end

  // ---- p1: redirect / trap pulses ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      redir_vld_p1 <= 1'b0;
      trap_vld_p1  <= 1'b0;
      redir_pc_p1  <= '0;
      trap_pc_p1   <= '0;
    end else begin
      redir_vld_p1 <= accept_p0 && taken_p0;
      trap_vld_p1  <= accept_p0 && trap_p0;
      // Target wraps modulo 2^WIDTH.
      if (accept_p0 && taken_p0)
        redir_pc_p1 <= bus.in_pc + WIDTH'(PC_INC) + bus.in_br_off;
      if (accept_p0 && trap_p0)
        trap_pc_p1 <= bus.in_pc;
    end
  end

  // A flush arriving while a pulse is on the wire cancels it.
  assign bus.redirect_valid = redir_vld_p1 && !flush;
  assign bus.redirect_pc    = redir_pc_p1;
  assign bus.ovf_trap       = trap_vld_p1 && !flush;
  assign bus.trap_pc        = trap_pc_p1;

endmodule

// File: tb/tb_alu_flag_resolve.sv
module tb_alu_flag_resolve;

  logic clk = 1'b0;
  logic rst_n;
  logic flush;

  always #5 clk = ~clk;

  alu_flag_resolve_if #(.WIDTH(32), .REG_AW(5)) ifc ();

  alu_flag_resolve #(.WIDTH(32), .REG_AW(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (ifc)
  );

  typedef struct packed {
    logic [31:0] s;
    logic        n;
    logic [4:0]  rd;
    logic        wr;
  } ent_t;

  // Reference model: a FIFO of at most two results plus pending pulses.
  ent_t        q[$];
  bit          m_trap_wait;
  bit          m_redir;
  logic [31:0] m_redir_pc;
  bit          m_trap;
  logic [31:0] m_trap_pc;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_check();
    bit   exp_ready;
    ent_t h;
    exp_ready = (q.size() < 2) && !m_trap_wait && !flush;
    chk("in_ready", ifc.in_ready, exp_ready);
    chk("out_valid", ifc.out_valid, q.size() > 0);
    if (q.size() > 0) begin
      h = q[0];
      chk("out_S", ifc.out_S, h.s);
      chk("out_N", ifc.out_N, h.n);
      chk("out_rd", ifc.out_rd, h.rd);
      chk("out_wr_en", ifc.out_wr_en, h.wr);
    end
    chk("redirect_valid", ifc.redirect_valid, m_redir && !flush);
    if (m_redir && !flush) chk("redirect_pc", ifc.redirect_pc, m_redir_pc);
    chk("ovf_trap", ifc.ovf_trap, m_trap && !flush);
    if (m_trap && !flush) chk("trap_pc", ifc.trap_pc, m_trap_pc);
    if (ifc.in_valid)
      chk("no_overflow", ifc.in_ready && (q.size() == 2), 1'b0);
  endtask

  task automatic model_update();
    bit   acc, pop, trap, taken;
    ent_t e;
    if (!rst_n) begin
      q.delete();
      m_trap_wait = 0; m_redir = 0; m_trap = 0;
      m_redir_pc = '0; m_trap_pc = '0;
    end else if (flush) begin
      q.delete();
      m_trap_wait = 0; m_redir = 0; m_trap = 0;
    end else begin
      acc = ifc.in_valid && (q.size() < 2) && !m_trap_wait;
      pop = (q.size() > 0) && ifc.out_ready;
      if (pop) void'(q.pop_front());
      case (ifc.in_br_cond)
        2'b01:   taken = !ifc.in_Z;
        2'b10:   taken = ifc.in_Z;
        2'b11:   taken = 1;
        default: taken = 0;
      endcase
      trap    = acc && ifc.in_sign && ifc.in_V;
      m_trap  = trap;
      m_redir = acc && taken && !trap;
      if (m_redir) m_redir_pc = ifc.in_pc + 32'd4 + ifc.in_br_off;
      if (trap) begin
        m_trap_pc   = ifc.in_pc;
        m_trap_wait = 1;
      end
      if (acc) begin
        e.s = ifc.in_S; e.n = ifc.in_N; e.rd = ifc.in_rd;
        e.wr = ifc.in_wr_en && !trap;
        q.push_back(e);
      end
    end
  endtask

  // One clock: settle, compare against the model, advance model, step edge.
  task automatic cycle();
    #1;
    if (rst_n) model_check();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] s, input logic z, input logic ov,
                       input logic n, input logic sg, input logic [1:0] c,
                       input logic [31:0] pc, input logic [31:0] off,
                       input logic [4:0] rd, input logic wr);
    ifc.in_valid = v; ifc.in_S = s; ifc.in_Z = z; ifc.in_V = ov; ifc.in_N = n;
    ifc.in_sign = sg; ifc.in_br_cond = c; ifc.in_pc = pc; ifc.in_br_off = off;
    ifc.in_rd = rd; ifc.in_wr_en = wr;
  endtask

  task automatic idle();
    ifc.in_valid = 1'b0;
  endtask

  task automatic reset_zero_checks(input string tag);
    chk({tag, "_out_valid"}, ifc.out_valid, 1'b0);
    chk({tag, "_in_ready"}, ifc.in_ready, 1'b1);
    chk({tag, "_redirect_valid"}, ifc.redirect_valid, 1'b0);
    chk({tag, "_ovf_trap"}, ifc.ovf_trap, 1'b0);
    chk({tag, "_out_S"}, ifc.out_S, 32'h0);
    chk({tag, "_out_rd"}, ifc.out_rd, 5'h0);
    chk({tag, "_out_wr_en"}, ifc.out_wr_en, 1'b0);
    chk({tag, "_redirect_pc"}, ifc.redirect_pc, 32'h0);
    chk({tag, "_trap_pc"}, ifc.trap_pc, 32'h0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
    ifc.out_ready = 1'b1;
    cycle();
    cycle();
    rst_n = 1'b1;
    #1;
    reset_zero_checks("por");

    // Four back-to-back accepts, MEM always ready.
    for (int i = 0; i < 4; i++) begin
      drive(1, 32'hA000_0000 + i, 0, 0, i[0], 0, 2'b00, 32'h40 + 4*i, 0, 5'(i + 1), 1);
      cycle();
      chk("b2b_in_ready", ifc.in_ready, 1'b1);
      chk("b2b_out_S", ifc.out_S, 32'hA000_0000 + i);
    end
    idle();
    repeat (2) cycle();

    // MEM stalls for three cycles while sending.
    ifc.out_ready = 1'b0;
    drive(1, 32'h1111, 0, 0, 0, 0, 2'b00, 32'h80, 0, 5'd3, 1);
    cycle();
    drive(1, 32'h2222, 0, 0, 1, 0, 2'b00, 32'h84, 0, 5'd4, 1);
    cycle();
    drive(1, 32'h3333, 0, 0, 0, 0, 2'b00, 32'h88, 0, 5'd5, 1);
    #1;
    chk("stall_in_ready_low", ifc.in_ready, 1'b0);
    cycle();
    cycle();
    chk("stall_head_held", ifc.out_S, 32'h1111);
    ifc.out_ready = 1'b1;
    cycle();
    chk("release_second", ifc.out_S, 32'h2222);
    repeat (2) cycle();
    idle();
    repeat (3) cycle();

    // Branch not-zero, taken.
    drive(1, 32'h5, 0, 0, 0, 0, 2'b01, 32'h100, 32'h20, 5'd6, 1);
    cycle();
    idle();
    chk("br_nz_pulse", ifc.redirect_valid, 1'b1);
    chk("br_nz_pc", ifc.redirect_pc, 32'h124);
    cycle();
    chk("br_nz_one_cycle", ifc.redirect_valid, 1'b0);
    // Branch not-zero with Z=1: not taken.
    drive(1, 32'h0, 1, 0, 0, 0, 2'b01, 32'h100, 32'h20, 5'd6, 1);
    cycle();
    idle();
    chk("br_nz_not_taken", ifc.redirect_valid, 1'b0);
    repeat (2) cycle();

    // Signed overflow trap.
    drive(1, 32'h7FFF_FFFF, 0, 1, 0, 1, 2'b00, 32'h200, 0, 5'd7, 1);
    cycle();
    idle();
    chk("trap_pulse", ifc.ovf_trap, 1'b1);
    chk("trap_pc", ifc.trap_pc, 32'h200);
    chk("trap_wr_en", ifc.out_wr_en, 1'b0);
    chk("trap_in_ready", ifc.in_ready, 1'b0);
    drive(1, 32'h9, 0, 0, 0, 0, 2'b00, 32'h204, 0, 5'd8, 1);
    repeat (3) cycle();
    chk("trap_wait_ready", ifc.in_ready, 1'b0);
    idle();
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    #1;
    chk("trap_released", ifc.in_ready, 1'b1);
    // Same op unsigned: V ignored.
    drive(1, 32'h7FFF_FFFF, 0, 1, 0, 0, 2'b00, 32'h200, 0, 5'd7, 1);
    cycle();
    idle();
    chk("unsigned_no_trap", ifc.ovf_trap, 1'b0);
    chk("unsigned_wr_en", ifc.out_wr_en, 1'b1);
    cycle();

    // Always-branch plus trap on the same instruction.
    drive(1, 32'h1, 0, 1, 0, 1, 2'b11, 32'h300, 32'h40, 5'd9, 1);
    cycle();
    idle();
    chk("br_trap_trap", ifc.ovf_trap, 1'b1);
    chk("br_trap_no_redirect", ifc.redirect_valid, 1'b0);
    flush = 1'b1;
    cycle();
    flush = 1'b0;

    // Flush on the cycle after a taken-branch accept.
    drive(1, 32'h2, 1, 0, 0, 0, 2'b10, 32'h400, 32'h10, 5'd10, 1);
    cycle();
    idle();
    flush = 1'b1;
    #1;
    chk("flush_cancels_redirect", ifc.redirect_valid, 1'b0);
    cycle();
    flush = 1'b0;
    chk("flush_empties", ifc.out_valid, 1'b0);
    // Flush coinciding with in_valid.
    drive(1, 32'h3, 0, 0, 0, 0, 2'b11, 32'h500, 32'h8, 5'd11, 1);
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    idle();
    chk("flush_no_accept", ifc.out_valid, 1'b0);
    chk("flush_no_redirect", ifc.redirect_valid, 1'b0);
    cycle();

    // Mid-operation reset with both entries occupied.
    ifc.out_ready = 1'b0;
    drive(1, 32'hDEAD, 0, 0, 1, 0, 2'b11, 32'h600, 32'h4, 5'd12, 1);
    cycle();
    drive(1, 32'hBEEF, 0, 1, 1, 1, 2'b00, 32'h604, 0, 5'd13, 1);
    cycle();
    idle();
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    ifc.out_ready = 1'b1;
    #1;
    reset_zero_checks("midrst");
    cycle();

    // Randomized traffic against the reference model.
    for (int i = 0; i < 500; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom, 1'($urandom_range(0, 1)),
            $urandom_range(0, 7) == 0, 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
            $urandom & 32'hFFFF_FFFC, $urandom, 5'($urandom_range(0, 31)),
            1'($urandom_range(0, 1)));
      ifc.out_ready = ($urandom_range(0, 3) != 0);
      flush = m_trap_wait ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 29) == 0);
      cycle();
    end
    flush = 1'b0;
    idle();
    ifc.out_ready = 1'b1;
    repeat (3) cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
